pipeline_ctrl: RTL and testbench

Hazard and flush controller for the four-stage pipeline (fetch, decode, execute, writeback). Keeps a 16-entry register scoreboard of in-flight writes, stalls fetch/decode on read-after-write hazards, drives the decode stage's invalidate to insert bubbles and flush wrong-path instructions after taken branches, and freezes the whole pipe while memory is busy. Sits beside the decode stage and drives its `clk_en` and `invalidate` inputs.

---
 rtl/pipeline_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/flush controller for the 4-stage pipe: register scoreboard, RAW stalls, branch flush, memory freeze.
// Optional PIPE_CTRL_PERF_EN adds a saturating hazard-stall cycle counter.
module pipeline_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sync_rst,
   input  logic        dec_valid,
   input  logic [3:0]  dec_rs1_addr,
   input  logic [3:0]  dec_rs2_addr,
   input  logic        dec_rs1_used,
   input  logic        dec_rs2_used,
   input  logic [3:0]  dec_rd_addr,
   input  logic        dec_rd_we,
   input  logic        ex_branch_taken,
   input  logic        mem_busy,
   input  logic        wb_we,
   input  logic [3:0]  wb_rd_addr,
   output logic        pipe_clk_en,
   output logic        fd_clk_en,
   output logic        dec_invalidate,
   output logic        flushing,
   output logic [15:0] scoreboard,
   output logic [15:0] perf_stall_cnt
);

   localparam int unsigned NREG = 16;
   localparam int unsigned CW   = 4;
   localparam int unsigned PW   = 16;
   localparam bit             FLUSH_EN   = (FLUSH_CYCLES > 1);
   localparam logic [CW-1:0]  FLUSH_LOAD = CW'(FLUSH_EN ? FLUSH_CYCLES - 2 : 0);

   typedef enum logic {RUN, FLUSH} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   flush_cnt_q, flush_cnt_d;
   logic [NREG-1:0] sb_q, sb_d;
   logic            flushing_q, flushing_d;
   logic            hazard_c;
   logic            issue_c;
   logic            stall_c;

   // Source hit on a pending write; register 0 is never a hazard.
   always_comb begin
      hazard_c = dec_valid &
                 ((dec_rs1_used & (dec_rs1_addr != '0) & sb_q[dec_rs1_addr]) |
                  (dec_rs2_used & (dec_rs2_addr != '0) & sb_q[dec_rs2_addr]));
   end

   // A taken branch overrides the stall so fetch moves to the target.
   assign stall_c        = hazard_c & (state_q == RUN) & ~ex_branch_taken;
   assign pipe_clk_en    = rst_n & ~mem_busy;
   assign fd_clk_en      = rst_n & ~mem_busy & ~stall_c;
   assign dec_invalidate = ~rst_n | sync_rst | hazard_c | ex_branch_taken | (state_q == FLUSH);
   assign issue_c        = dec_valid & pipe_clk_en & ~dec_invalidate;

   // Next state: everything frozen while memory is busy; set beats clear.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      sb_d        = sb_q;
      if (sync_rst) begin
         state_d     = RUN;
         flush_cnt_d = '0;
         sb_d        = '0;
      end else if (pipe_clk_en) begin
         if (wb_we) begin
            sb_d[wb_rd_addr] = 1'b0;
         end
         if (issue_c && dec_rd_we && (dec_rd_addr != '0)) begin
            sb_d[dec_rd_addr] = 1'b1;
         end
         if (ex_branch_taken) begin
            if (FLUSH_EN) begin
               state_d     = FLUSH;
               flush_cnt_d = FLUSH_LOAD;
            end
         end else if (state_q == FLUSH) begin
            if (flush_cnt_q == '0) begin
               state_d = RUN;
            end else begin
               flush_cnt_d = flush_cnt_q - CW'(1);
            end
         end
      end
      sb_d[0]    = 1'b0;
      flushing_d = (state_d == FLUSH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         flush_cnt_q <= '0;
         sb_q        <= '0;
         flushing_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         sb_q        <= sb_d;
         flushing_q  <= flushing_d;
      end
   end

   assign scoreboard = sb_q;
   assign flushing   = flushing_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [PW-1:0] perf_q, perf_d;

   // Counts true hazard stalls only, saturating at all-ones.
   always_comb begin
      perf_d = perf_q;
      if (sync_rst) begin
         perf_d = '0;
      end else if (hazard_c && !fd_clk_en && !mem_busy && (perf_q != '1)) begin
         perf_d = perf_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_stall_cnt = perf_q;
`else
   assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with FLUSH_CYCLES=3.
module tb_pipeline_ctrl;

`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sync_rst;
   logic        dec_valid;
   logic [3:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr, wb_rd_addr;
   logic        dec_rs1_used, dec_rs2_used, dec_rd_we;
   logic        ex_branch_taken, mem_busy, wb_we;
   logic        pipe_clk_en, fd_clk_en, dec_invalidate, flushing;
   logic [15:0] scoreboard, perf_stall_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.FLUSH_CYCLES(3)) dut (
      .clk(clk), .rst_n(rst_n), .sync_rst(sync_rst),
      .dec_valid(dec_valid), .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
      .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
      .dec_rd_addr(dec_rd_addr), .dec_rd_we(dec_rd_we),
      .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
      .wb_we(wb_we), .wb_rd_addr(wb_rd_addr),
      .pipe_clk_en(pipe_clk_en), .fd_clk_en(fd_clk_en), .dec_invalidate(dec_invalidate),
      .flushing(flushing), .scoreboard(scoreboard), .perf_stall_cnt(perf_stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dec(input logic v, input logic [3:0] rs1, input logic u1,
                      input logic [3:0] rs2, input logic u2,
                      input logic [3:0] rd, input logic we);
      dec_valid    = v;
      dec_rs1_addr = rs1;
      dec_rs1_used = u1;
      dec_rs2_addr = rs2;
      dec_rs2_used = u2;
      dec_rd_addr  = rd;
      dec_rd_we    = we;
   endtask

   task automatic wb(input logic we, input logic [3:0] rd);
      wb_we      = we;
      wb_rd_addr = rd;
   endtask

   task automatic idle();
      dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      wb(1'b0, 4'd0);
      ex_branch_taken = 1'b0;
      mem_busy        = 1'b0;
      sync_rst        = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      // Reset held with random inputs.
      for (int i = 0; i < 3; i++) begin
         dec(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
             4'($urandom), 1'($urandom));
         wb(1'($urandom), 4'($urandom));
         ex_branch_taken = 1'($urandom);
         mem_busy        = 1'($urandom);
         tick();
         chk("rst_sb", 32'(scoreboard), 32'h0);
         chk("rst_inv", 32'(dec_invalidate), 32'd1);
         chk("rst_pce", 32'(pipe_clk_en), 32'd0);
         chk("rst_fdce", 32'(fd_clk_en), 32'd0);
      end
      chk("rst_flush", 32'(flushing), 32'd0);
      chk("rst_perf", 32'(perf_stall_cnt), 32'd0);
      idle();
      rst_n = 1'b1;
      #1;
      chk("idle_fdce", 32'(fd_clk_en), 32'd1);
      chk("idle_inv", 32'(dec_invalidate), 32'd0);
      chk("idle_pce", 32'(pipe_clk_en), 32'd1);
      tick();

      // RAW stall on r3.
      dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1);
      #1 chk("w3_inv", 32'(dec_invalidate), 32'd0);
      tick();
      chk("w3_sb", 32'(scoreboard), 32'h0008);
      dec(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1);
      #1 chk("raw1_fdce", 32'(fd_clk_en), 32'd0);
      chk("raw1_inv", 32'(dec_invalidate), 32'd1);
      tick();
      chk("raw2_fdce", 32'(fd_clk_en), 32'd0);
      chk("raw2_inv", 32'(dec_invalidate), 32'd1);
      tick();
      wb(1'b1, 4'd3);
      #1 chk("raw3_nobypass", 32'(fd_clk_en), 32'd0);
      tick();
      wb(1'b0, 4'd0);
      chk("raw_clr_sb", 32'(scoreboard), 32'h0000);
      chk("raw_perf", 32'(perf_stall_cnt), PERF ? 32'd3 : 32'd0);
      #1 chk("raw_rel_fdce", 32'(fd_clk_en), 32'd1);
      chk("raw_rel_inv", 32'(dec_invalidate), 32'd0);
      tick();
      chk("w4_sb", 32'(scoreboard), 32'h0010);
      dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      wb(1'b1, 4'd4);
      tick();
      wb(1'b0, 4'd0);
      chk("c4_sb", 32'(scoreboard), 32'h0000);

      // r0 is never pending; unused sources never stall.
      dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
      tick();
      chk("r0_sb", 32'(scoreboard), 32'h0000);
      dec(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0);
      #1 chk("r0_fdce", 32'(fd_clk_en), 32'd1);
      chk("r0_inv", 32'(dec_invalidate), 32'd0);
      tick();
      dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1);
      tick();
      chk("w6_sb", 32'(scoreboard), 32'h0040);
      dec(1'b1, 4'd1, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0);
      #1 chk("unused_fdce", 32'(fd_clk_en), 32'd1);
      chk("unused_inv", 32'(dec_invalidate), 32'd0);
      tick();
      dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      wb(1'b1, 4'd6);
      tick();
      wb(1'b0, 4'd0);
      chk("c6_sb", 32'(scoreboard), 32'h0000);

      // Branch flush: 3 invalidate cycles, 2 in FLUSH.
      ex_branch_taken = 1'b1;
      #1 chk("br0_inv", 32'(dec_invalidate), 32'd1);
      chk("br0_fdce", 32'(fd_clk_en), 32'd1);
      tick();
      ex_branch_taken = 1'b0;
      chk("br1_flush", 32'(flushing), 32'd1);
      #1 chk("br1_inv", 32'(dec_invalidate), 32'd1);
      tick();
      chk("br2_flush", 32'(flushing), 32'd1);
      chk("br2_inv", 32'(dec_invalidate), 32'd1);
      tick();
      chk("br3_flush", 32'(flushing), 32'd0);
      chk("br3_inv", 32'(dec_invalidate), 32'd0);

      // Second branch inside the flush restarts the count.
      ex_branch_taken = 1'b1;
      tick();
      tick();
      ex_branch_taken = 1'b0;
      chk("rb1_flush", 32'(flushing), 32'd1);
      tick();
      chk("rb2_flush", 32'(flushing), 32'd1);
      tick();
      chk("rb3_flush", 32'(flushing), 32'd0);

      // Branch during hazard: reader discarded, stall overridden.
      dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1);
      tick();
      chk("w5_sb", 32'(scoreboard), 32'h0020);
      dec(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1);
      #1 chk("bh_stall", 32'(fd_clk_en), 32'd0);
      tick();
      ex_branch_taken = 1'b1;
      #1 chk("bh_fdce", 32'(fd_clk_en), 32'd1);
      chk("bh_inv", 32'(dec_invalidate), 32'd1);
      tick();
      ex_branch_taken = 1'b0;
      dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      chk("bh_sb", 32'(scoreboard), 32'h0020);
      chk("bh_perf", 32'(perf_stall_cnt), PERF ? 32'd4 : 32'd0);
      wb(1'b1, 4'd5);
      tick();
      wb(1'b0, 4'd0);
      chk("c5_sb", 32'(scoreboard), 32'h0000);
      tick();
      chk("bh_done", 32'(flushing), 32'd0);

      // mem_busy mid-flush with a retiring write: everything holds.
      dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1);
      tick();
      dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      chk("w7_sb", 32'(scoreboard), 32'h0080);
      ex_branch_taken = 1'b1;
      tick();
      ex_branch_taken = 1'b0;
      mem_busy = 1'b1;
      wb(1'b1, 4'd7);
      for (int i = 0; i < 4; i++) begin
         #1 chk("mb_pce", 32'(pipe_clk_en), 32'd0);
         chk("mb_fdce", 32'(fd_clk_en), 32'd0);
         chk("mb_inv", 32'(dec_invalidate), 32'd1);
         tick();
         chk("mb_sb", 32'(scoreboard), 32'h0080);
         chk("mb_flush", 32'(flushing), 32'd1);
      end
      mem_busy = 1'b0;
      wb(1'b0, 4'd0);
      tick();
      chk("mb_res1", 32'(flushing), 32'd1);
      tick();
      chk("mb_res2", 32'(flushing), 32'd0);
      chk("mb_sb_end", 32'(scoreboard), 32'h0080);

      // Set and clear of the same register in one cycle: set wins.
      wb(1'b1, 4'd7);
      tick();
      dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1);
      wb(1'b1, 4'd8);
      tick();
      idle();
      chk("setwins_sb", 32'(scoreboard), 32'h0100);

      // Synchronous clear mid-flush.
      ex_branch_taken = 1'b1;
      tick();
      ex_branch_taken = 1'b0;
      sync_rst = 1'b1;
      #1 chk("srst_inv", 32'(dec_invalidate), 32'd1);
      tick();
      sync_rst = 1'b0;
      chk("srst_sb", 32'(scoreboard), 32'h0000);
      chk("srst_flush", 32'(flushing), 32'd0);
      chk("srst_perf", 32'(perf_stall_cnt), 32'd0);
      #1 chk("srst_rel_inv", 32'(dec_invalidate), 32'd0);

      // Asynchronous reset mid-stall drops pending state immediately.
      dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1);
      tick();
      dec(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
      tick();
      chk("ar_pre_sb", 32'(scoreboard), 32'h0004);
      #1 rst_n = 1'b0;
      #1 chk("ar_sb", 32'(scoreboard), 32'h0000);
      chk("ar_pce", 32'(pipe_clk_en), 32'd0);
      rst_n = 1'b1;
      #1 chk("ar_fdce", 32'(fd_clk_en), 32'd1);
      chk("ar_inv", 32'(dec_invalidate), 32'd0);
      idle();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
